// File: rtl/exec_ctrl_mem_unit_if.sv
// exec_ctrl_mem_unit_if: decode, ALU and data-memory signals of exec_ctrl_mem_unit
interface exec_ctrl_mem_unit_if;
  logic [16:0] cu_info;
  logic        nop;
  logic        we_reg;
  logic        we_mem;
  logic [2:0]  rf_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  op2_sel;
  logic        is_load;
  logic        is_signed;
  logic [1:0]  word_length;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_op;
  logic        alu_signed;
  logic [31:0] alu_out;
  logic        z;
  logic        n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  modport master (
    output cu_info, nop, op1, op2, alu_op, alu_signed, mem_addr, mem_wdata, mem_we,
    input  we_reg, we_mem, rf_sel, alu_sel, op2_sel, is_load, is_signed, word_length,
    input  alu_out, z, n, mem_rdata
  );
  modport slave (
    input  cu_info, nop, op1, op2, alu_op, alu_signed, mem_addr, mem_wdata, mem_we,
    output we_reg, we_mem, rf_sel, alu_sel, op2_sel, is_load, is_signed, word_length,
    output alu_out, z, n, mem_rdata
  );
endinterface

// File: rtl/exec_ctrl_mem_unit.sv
// exec_ctrl_mem_unit: RV32I decode control, 32-bit ALU and word-addressed data memory
module exec_ctrl_mem_unit #(
  parameter int DMEM_WORDS = 1024
) (
  input logic clk,
  input logic rst,
  exec_ctrl_mem_unit_if.slave bus
);
  localparam int AW = $clog2(DMEM_WORDS);
  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;
  logic [3:0] arith_sel;
  logic       we_reg, we_mem, is_load, is_signed, valid;
  logic [2:0] rf_sel;
  logic [3:0] alu_sel;
  logic [1:0] op2_sel, word_length;
  logic       lt;
  logic [4:0] sh;
  logic       in_range;
  logic [AW-1:0] idx;
  logic [31:0] mem [DMEM_WORDS] = '{default: '0};
  assign opc  = bus.cu_info[6:0];
  assign f3   = bus.cu_info[9:7];
  assign f7b5 = bus.cu_info[15];
  assign arith_sel = f3 == 3'b000 ? ((opc == 7'b0110011 && f7b5) ? 4'b0001 : 4'b0000) :
                     f3 == 3'b001 ? 4'b0101 :
                     f3[2:1] == 2'b01 ? 4'b1000 :
                     f3 == 3'b100 ? 4'b0100 :
                     f3 == 3'b101 ? (f7b5 ? 4'b0111 : 4'b0110) :
                     f3 == 3'b110 ? 4'b0011 : 4'b0010;
  // decode opcode into control fields; unknown opcodes, nop and reset become a bubble
  always_comb begin
    we_reg = 1'b0;
    we_mem = 1'b0;
    rf_sel = 3'b000;
    alu_sel = 4'b0000;
    op2_sel = 2'b11;
    is_load = 1'b0;
    is_signed = 1'b1;
    word_length = 2'b10;
    valid = 1'b1;
    case (opc)
      7'b0110011: begin we_reg = 1'b1; alu_sel = arith_sel; is_signed = f3 != 3'b011; end
      7'b0010011: begin we_reg = 1'b1; alu_sel = arith_sel; is_signed = f3 != 3'b011; op2_sel = 2'b00; end
      7'b0000011: begin we_reg = 1'b1; rf_sel = 3'b001; op2_sel = 2'b00; is_load = 1'b1; is_signed = ~f3[2]; word_length = f3[1:0]; end
      7'b0100011: begin we_mem = 1'b1; op2_sel = 2'b01; word_length = f3[1:0]; end
      7'b1100011: begin alu_sel = 4'b0001; is_signed = ~f3[1]; end
      7'b1101111: begin we_reg = 1'b1; rf_sel = 3'b011; op2_sel = 2'b10; end
      7'b1100111: begin we_reg = 1'b1; rf_sel = 3'b011; op2_sel = 2'b00; end
      7'b0110111: begin we_reg = 1'b1; rf_sel = 3'b010; end
      7'b0010111: begin we_reg = 1'b1; rf_sel = 3'b100; end
      default: valid = 1'b0;
    endcase
    {bus.we_reg, bus.we_mem, bus.rf_sel, bus.alu_sel, bus.op2_sel, bus.is_load, bus.is_signed, bus.word_length} =
      (rst || bus.nop || !valid) ? 15'd0 :
      {we_reg, we_mem, rf_sel, alu_sel, op2_sel, is_load, is_signed, word_length};
  end
  assign sh = bus.op2[4:0];
  assign lt = bus.alu_signed ? ($signed(bus.op1) < $signed(bus.op2)) : (bus.op1 < bus.op2);
  assign bus.n = lt;
  assign bus.z = bus.alu_out == 32'd0;
  // ALU result; compare ops reuse the n comparator
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_out = bus.op1 + bus.op2;
      4'b0001: bus.alu_out = bus.op1 - bus.op2;
      4'b0010: bus.alu_out = bus.op1 & bus.op2;
      4'b0011: bus.alu_out = bus.op1 | bus.op2;
      4'b0100: bus.alu_out = bus.op1 ^ bus.op2;
      4'b0101: bus.alu_out = bus.op1 << sh;
      4'b0110: bus.alu_out = bus.op1 >> sh;
      4'b0111: bus.alu_out = $signed(bus.op1) >>> sh;
      4'b1000: bus.alu_out = {31'd0, lt};
      4'b1001: bus.alu_out = bus.op2;
      default: bus.alu_out = 32'd0;
    endcase
  end
  assign in_range = bus.mem_addr[31:AW+2] == '0;
  assign idx = bus.mem_addr[AW+1:2];
  assign bus.mem_rdata = in_range ? mem[idx] : 32'd0;
  // word write; reset only blocks writes, contents survive it
  always_ff @(posedge clk) begin
    if (bus.mem_we && !rst && in_range) mem[idx] <= bus.mem_wdata;
  end
endmodule

// File: tb/tb_exec_ctrl_mem_unit.sv
// tb_exec_ctrl_mem_unit: directed checks of decode, ALU and data memory
module tb_exec_ctrl_mem_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exec_ctrl_mem_unit_if bus ();
  exec_ctrl_mem_unit #(.DMEM_WORDS(1024)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  wire [14:0] cu = {bus.we_reg, bus.we_mem, bus.rf_sel, bus.alu_sel, bus.op2_sel, bus.is_load, bus.is_signed, bus.word_length};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.alu_op = op;
    bus.op1 = a;
    bus.op2 = b;
    bus.alu_signed = s;
    #1;
  endtask
  initial begin
    bus.cu_info = {7'd0, 3'b010, 7'b0000011};
    bus.nop = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.alu_op = '0;
    bus.alu_signed = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_we = 1'b0;
    #1;
    chk("cu_rst_lw", {17'd0, cu}, {17'd0, 15'b0_0_000_0000_00_0_0_00});
    chk("mem_init", bus.mem_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cu_lw", {17'd0, cu}, {17'd0, 15'b1_0_001_0000_00_1_1_10});
    bus.cu_info = {7'd0, 3'b100, 7'b0000011}; #1;
    chk("cu_lbu", {17'd0, cu}, {17'd0, 15'b1_0_001_0000_00_1_0_00});
    bus.cu_info = {7'b0100000, 3'b000, 7'b0110011}; #1;
    chk("cu_sub", {17'd0, cu}, {17'd0, 15'b1_0_000_0001_11_0_1_10});
    bus.nop = 1'b1; #1;
    chk("cu_sub_nop", {17'd0, cu}, 32'd0);
    bus.nop = 1'b0; rst = 1'b1; #1;
    chk("cu_sub_rst", {17'd0, cu}, 32'd0);
    rst = 1'b0;
    bus.cu_info = {7'd0, 3'b110, 7'b1100011}; #1;
    chk("cu_bltu", {17'd0, cu}, {17'd0, 15'b0_0_000_0001_11_0_0_10});
    bus.cu_info = {7'd0, 3'b011, 7'b0110011}; #1;
    chk("cu_sltu", {17'd0, cu}, {17'd0, 15'b1_0_000_1000_11_0_0_10});
    bus.cu_info = {7'b0100000, 3'b101, 7'b0010011}; #1;
    chk("cu_srai", {17'd0, cu}, {17'd0, 15'b1_0_000_0111_00_0_1_10});
    bus.cu_info = {7'b0100000, 3'b000, 7'b0010011}; #1;
    chk("cu_addi_f7", {17'd0, cu}, {17'd0, 15'b1_0_000_0000_00_0_1_10});
    bus.cu_info = {7'd0, 3'b010, 7'b0100011}; #1;
    chk("cu_sw", {17'd0, cu}, {17'd0, 15'b0_1_000_0000_01_0_1_10});
    bus.cu_info = {7'd0, 3'b000, 7'b1101111}; #1;
    chk("cu_jal", {17'd0, cu}, {17'd0, 15'b1_0_011_0000_10_0_1_10});
    bus.cu_info = {7'd0, 3'b000, 7'b0010111}; #1;
    chk("cu_auipc", {17'd0, cu}, {17'd0, 15'b1_0_100_0000_11_0_1_10});
    bus.cu_info = 17'd0; #1;
    chk("cu_op0", {17'd0, cu}, 32'd0);
    alu(4'b0001, 32'd5, 32'd7, 1'b1);
    chk("sub_out", bus.alu_out, 32'hFFFFFFFE);
    chk("sub_n", {31'd0, bus.n}, 32'd1);
    chk("sub_z", {31'd0, bus.z}, 32'd0);
    alu(4'b0000, 32'hFFFFFFFF, 32'd1, 1'b0);
    chk("add_wrap", bus.alu_out, 32'd0);
    chk("add_z", {31'd0, bus.z}, 32'd1);
    chk("add_n_uns", {31'd0, bus.n}, 32'd0);
    alu(4'b1000, 32'hFFFFFFFF, 32'd1, 1'b1);
    chk("slt_s", bus.alu_out, 32'd1);
    alu(4'b1000, 32'hFFFFFFFF, 32'd1, 1'b0);
    chk("slt_u", bus.alu_out, 32'd0);
    alu(4'b0111, 32'h80000000, 32'h21, 1'b0);
    chk("sra", bus.alu_out, 32'hC0000000);
    alu(4'b0110, 32'h80000000, 32'h21, 1'b0);
    chk("srl", bus.alu_out, 32'h40000000);
    alu(4'b0101, 32'd1, 32'h24, 1'b0);
    chk("sll", bus.alu_out, 32'h10);
    alu(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    chk("xor", bus.alu_out, 32'h0FF00FF0);
    alu(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    chk("and", bus.alu_out, 32'hF000F000);
    alu(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    chk("or", bus.alu_out, 32'hFFF0FFF0);
    alu(4'b1001, 32'd3, 32'h1234, 1'b0);
    chk("pass", bus.alu_out, 32'h1234);
    alu(4'b1010, 32'd3, 32'h1234, 1'b0);
    chk("op1010", bus.alu_out, 32'd0);
    @(negedge clk);
    bus.mem_addr = 32'h10; bus.mem_wdata = 32'hDEADBEEF; bus.mem_we = 1'b1; #1;
    chk("rdw_old", bus.mem_rdata, 32'd0);
    @(posedge clk); #1;
    chk("wr_10", bus.mem_rdata, 32'hDEADBEEF);
    @(negedge clk);
    bus.mem_we = 1'b0; bus.mem_addr = 32'h13; #1;
    chk("rd_13", bus.mem_rdata, 32'hDEADBEEF);
    bus.mem_addr = 32'h14; #1;
    chk("rd_14", bus.mem_rdata, 32'd0);
    rst = 1'b1; bus.mem_addr = 32'h10; bus.mem_wdata = 32'h12345678; bus.mem_we = 1'b1;
    @(posedge clk); #1;
    chk("wr_rst", bus.mem_rdata, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b0; bus.mem_addr = 32'h8000; bus.mem_wdata = 32'h55; bus.mem_we = 1'b1;
    @(posedge clk); #1;
    chk("rd_8000", bus.mem_rdata, 32'd0);
    @(negedge clk);
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0; #1;
    chk("rd_0_alias", bus.mem_rdata, 32'd0);
    bus.mem_addr = 32'h10; #1;
    chk("rd_10_keep", bus.mem_rdata, 32'hDEADBEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
